gcd_scheduler: RTL and testbench

Round-robin scheduler that shares one subtract-based GCD core (control unit plus datapath) between N requesters. It latches the winning requester's operands and drives them to the core. It releases the core from reset to start a run, then returns the result to the owner. Zero operands bypass the core, since the subtract loop never terminates on them. A watchdog aborts runs that do not finish.

---
 rtl/gcd_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/gcd_scheduler.sv | 137 +++++++++++++
 tb/tb_gcd_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD scheduler: FSM state encoding and the
// default watchdog limit derived from the operand width.
package gcd_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Generous bound on subtract-loop cycles for a given operand width.
  function automatic int max_cyc_default(input int size);
    return 2 ** (size + 2);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// after ptr, wrapping cyclically.
module rr_arbiter
  import gcd_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        idx = PW'((int'(ptr) + k) % N);
        grant[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_scheduler.sv
// Shares one subtract-based GCD core between N requesters: round-robin
// acceptance, zero-operand bypass, watchdog abort, result return to owner.
module gcd_scheduler
  import gcd_pkg::*;
#(
  parameter int N       = 4,
  parameter int size    = 8,
  parameter int MAX_CYC = max_cyc_default(size)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N*size-1:0] a_in,
  input  logic [N*size-1:0] b_in,
  output logic [N-1:0]      gnt,
  output logic [N-1:0]      done,
  output logic [size-1:0]   result,
  output logic              err,
  output logic              core_rst,
  output logic [size-1:0]   core_x,
  output logic [size-1:0]   core_y,
  input  logic              core_done,
  input  logic [size-1:0]   core_result
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYC - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_CYC);

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [size-1:0] res_q, res_d;
  logic            err_q, err_d;
  logic [size-1:0] x_q, x_d;
  logic [size-1:0] y_q, y_d;

  logic [N-1:0]    arb_grant;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;
  logic [size-1:0] a_sel, b_sel;
  logic [PW-1:0]   ptr_next;

  rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign a_sel    = a_in[int'(arb_idx) * size +: size];
  assign b_sel    = b_in[int'(arb_idx) * size +: size];
  assign ptr_next = (arb_idx == PW'(N - 1)) ? '0 : arb_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          owner_d = arb_idx;
          x_d     = a_sel;
          y_d     = b_sel;
          ptr_d   = ptr_next;
          // A zero operand would spin the subtract loop forever.
          if (a_sel == '0 || b_sel == '0) begin
            res_d   = a_sel | b_sel;
            err_d   = 1'b0;
            state_d = ST_RESP;
          end else begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        if (core_done) begin
          res_d   = core_result;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q >= CNT_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt      = (rst && state_q == ST_IDLE) ? arb_grant : '0;
    done     = '0;
    for (int i = 0; i < N; i++) begin
      done[i] = (state_q == ST_RESP) && (owner_q == PW'(i));
    end
    result   = (state_q == ST_RESP) ? res_q : '0;
    err      = (state_q == ST_RESP) ? err_q : 1'b0;
    core_rst = (state_q != ST_RUN);
    core_x   = x_q;
    core_y   = y_q;
  end

endmodule

// File: tb/tb_gcd_scheduler.sv
// Directed bench for gcd_scheduler: a behavioural subtract-GCD core on the
// default instance and a controllable core stub on a MAX_CYC=16 instance.
module tb_gcd_scheduler;

  localparam int N  = 4;
  localparam int SZ = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req, gnt, done;
  logic [N*SZ-1:0] a_in, b_in;
  logic [SZ-1:0]   result, core_x, core_y, core_result;
  logic            err, core_rst, core_done;

  logic [N-1:0]    w_req, w_gnt, w_done;
  logic [N*SZ-1:0] w_a, w_b;
  logic [SZ-1:0]   w_result, w_core_x, w_core_y, w_core_result;
  logic            w_err, w_core_rst, w_core_done;

  int tests = 0;
  int fails = 0;

  gcd_scheduler #(.N(N), .size(SZ)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .result(result), .err(err),
    .core_rst(core_rst), .core_x(core_x), .core_y(core_y),
    .core_done(core_done), .core_result(core_result)
  );

  gcd_scheduler #(.N(N), .size(SZ), .MAX_CYC(16)) dut_wd (
    .clk(clk), .rst(rst), .req(w_req), .a_in(w_a), .b_in(w_b),
    .gnt(w_gnt), .done(w_done), .result(w_result), .err(w_err),
    .core_rst(w_core_rst), .core_x(w_core_x), .core_y(w_core_y),
    .core_done(w_core_done), .core_result(w_core_result)
  );

  // Behavioural core: START loads, CMP tests equality, SUB subtracts, END holds.
  logic [1:0]    cst;
  logic [SZ-1:0] cx, cy;
  always @(posedge clk) begin
    if (core_rst) cst <= 2'd0;
    else begin
      case (cst)
        2'd0: begin cx <= core_x; cy <= core_y; cst <= 2'd1; end
        2'd1: cst <= (cx == cy) ? 2'd3 : 2'd2;
        2'd2: begin
          if (cx > cy) cx <= cx - cy; else cy <= cy - cx;
          cst <= 2'd1;
        end
        default: cst <= 2'd3;
      endcase
    end
  end
  assign core_done   = (cst == 2'd3);
  assign core_result = cx;

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic set_op(input int i, input logic [SZ-1:0] a, input logic [SZ-1:0] b);
    a_in[i*SZ +: SZ] = a;
    b_in[i*SZ +: SZ] = b;
  endtask

  task automatic wait_done(input int limit, input logic [N-1:0] drop,
                           output int lat, output bit run_low);
    lat = -1;
    run_low = 1'b1;
    for (int k = 1; k <= limit; k++) begin
      step();
      if (k == 1) req = req & ~drop;
      if (done !== '0) begin lat = k; break; end
      if (core_rst !== 1'b0) run_low = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b1111; w_req = '0;
    set_op(0, 8'd12, 8'd8);
    step(); step();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    tests++; if (done !== 4'b0000) begin fails++; $display("FAIL reset_done: got %b want 0000", done); end
    tests++; if (result !== 8'd0) begin fails++; $display("FAIL reset_result: got %0d want 0", result); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    tests++; if (core_rst !== 1'b1) begin fails++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
    tests++; if (core_x !== 8'd0 || core_y !== 8'd0) begin fails++; $display("FAIL reset_core_xy: got %0d/%0d want 0/0", core_x, core_y); end
    req = '0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    int lat; bit low;
    set_op(0, 8'd48, 8'd18);
    req = 4'b0001; #1;
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    tests++; if (core_rst !== 1'b1) begin fails++; $display("FAIL single_core_rst_idle: got %b want 1", core_rst); end
    wait_done(600, 4'b0001, lat, low);
    tests++; if (lat !== 12) begin fails++; $display("FAIL single_latency: got %0d want 12", lat); end
    tests++; if (done !== 4'b0001) begin fails++; $display("FAIL single_done: got %b want 0001", done); end
    tests++; if (result !== 8'd6) begin fails++; $display("FAIL single_result: got %0d want 6", result); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL single_err: got %b want 0", err); end
    tests++; if (low !== 1'b1) begin fails++; $display("FAIL single_core_rst_run: got %b want 1 (low whole run)", low); end
    tests++; if (core_rst !== 1'b1) begin fails++; $display("FAIL single_core_rst_resp: got %b want 1", core_rst); end
    step();
    tests++; if (done !== 4'b0000) begin fails++; $display("FAIL single_done_pulse: got %b want 0000", done); end
  endtask

  task automatic test_contention();
    int lat; bit low;
    int order [6];
    logic [SZ-1:0] exp_r [4];
    logic [N-1:0] eg;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0; order[5] = 3;
    exp_r[0] = 8'd4; exp_r[1] = 8'd3; exp_r[2] = 8'd2; exp_r[3] = 8'd7;
    rst = 1'b0; step(); rst = 1'b1;
    set_op(0, 8'd12, 8'd8); set_op(1, 8'd9, 8'd6);
    set_op(2, 8'd10, 8'd4); set_op(3, 8'd14, 8'd21);
    req = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      if (n == 4) req = 4'b1001;
      #1;
      eg = 4'b0001 << order[n];
      tests++; if (gnt !== eg) begin fails++; $display("FAIL contention_gnt%0d: got %b want %b", n, gnt, eg); end
      wait_done(100, eg, lat, low);
      tests++; if (done !== eg) begin fails++; $display("FAIL contention_done%0d: got %b want %b", n, done, eg); end
      tests++; if (result !== exp_r[order[n]]) begin fails++; $display("FAIL contention_result%0d: got %0d want %0d", n, result, exp_r[order[n]]); end
      step();
    end
    req = '0;
  endtask

  task automatic test_bypass();
    set_op(1, 8'd0, 8'd25);
    req = 4'b0010; #1;
    tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL bypass_gnt: got %b want 0010", gnt); end
    step(); req = '0;
    tests++; if (done !== 4'b0010) begin fails++; $display("FAIL bypass_done: got %b want 0010", done); end
    tests++; if (result !== 8'd25) begin fails++; $display("FAIL bypass_result: got %0d want 25", result); end
    tests++; if (core_rst !== 1'b1) begin fails++; $display("FAIL bypass_core_rst: got %b want 1", core_rst); end
    step();
    tests++; if (core_rst !== 1'b1 || done !== 4'b0000) begin fails++; $display("FAIL bypass_after: got core_rst=%b done=%b want 1/0000", core_rst, done); end
    set_op(2, 8'd0, 8'd0);
    req = 4'b0100; #1;
    step(); req = '0;
    tests++; if (done !== 4'b0100 || result !== 8'd0 || err !== 1'b0) begin fails++; $display("FAIL bypass_zero: got done=%b result=%0d err=%b want 0100/0/0", done, result, err); end
    step();
    set_op(3, 8'd40, 8'd0);
    req = 4'b1000; #1;
    step(); req = '0;
    tests++; if (done !== 4'b1000 || result !== 8'd40) begin fails++; $display("FAIL bypass_b0: got done=%b result=%0d want 1000/40", done, result); end
    step();
  endtask

  task automatic test_back_to_back();
    set_op(0, 8'd0, 8'd7); set_op(1, 8'd5, 8'd0);
    req = 4'b0011; #1;
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL b2b_gnt0: got %b want 0001", gnt); end
    step(); req = 4'b0010;
    tests++; if (done !== 4'b0001 || result !== 8'd7) begin fails++; $display("FAIL b2b_done0: got done=%b result=%0d want 0001/7", done, result); end
    step();
    tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL b2b_gnt1: got %b want 0010", gnt); end
    step(); req = '0;
    tests++; if (done !== 4'b0010 || result !== 8'd5) begin fails++; $display("FAIL b2b_done1: got done=%b result=%0d want 0010/5", done, result); end
    step();
  endtask

  task automatic test_watchdog();
    int lat; bit early;
    w_core_done = 1'b0; w_core_result = 8'd0;
    w_a[1*SZ +: SZ] = 8'd48; w_b[1*SZ +: SZ] = 8'd18;
    w_req = 4'b0010; #1;
    tests++; if (w_gnt !== 4'b0010) begin fails++; $display("FAIL wd_gnt: got %b want 0010", w_gnt); end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1) begin
        w_req = '0;
        tests++; if (w_core_rst !== 1'b0) begin fails++; $display("FAIL wd_core_rst_run: got %b want 0", w_core_rst); end
      end
      if (w_done !== '0) begin lat = k; break; end
    end
    tests++; if (lat !== 17) begin fails++; $display("FAIL wd_latency: got %0d want 17", lat); end
    tests++; if (w_done !== 4'b0010 || w_err !== 1'b1 || w_result !== 8'd0) begin fails++; $display("FAIL wd_timeout: got done=%b err=%b result=%0d want 0010/1/0", w_done, w_err, w_result); end
    step();
    tests++; if (w_done !== 4'b0000 || w_err !== 1'b0) begin fails++; $display("FAIL wd_after: got done=%b err=%b want 0000/0", w_done, w_err); end
    w_a[2*SZ +: SZ] = 8'd9; w_b[2*SZ +: SZ] = 8'd6;
    w_req = 4'b0100; #1;
    early = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) w_req = '0;
      if (w_done !== '0) early = 1'b1;
      if (k == 16) begin w_core_done = 1'b1; w_core_result = 8'd3; end
    end
    step();
    tests++; if (early !== 1'b0) begin fails++; $display("FAIL wd_early_done: got %b want 0", early); end
    tests++; if (w_done !== 4'b0100 || w_err !== 1'b0 || w_result !== 8'd3) begin fails++; $display("FAIL wd_priority: got done=%b err=%b result=%0d want 0100/0/3", w_done, w_err, w_result); end
    w_core_done = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_run();
    int lat; bit low; bit seen;
    set_op(2, 8'd255, 8'd1);
    req = 4'b0100; #1;
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL midrst_gnt: got %b want 0100", gnt); end
    step(); req = '0;
    step(); step(); step();
    tests++; if (core_rst !== 1'b0) begin fails++; $display("FAIL midrst_running: got core_rst=%b want 0", core_rst); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    tests++; if (gnt !== 4'b0000 || done !== 4'b0000 || result !== 8'd0 || err !== 1'b0) begin fails++; $display("FAIL midrst_outputs: got gnt=%b done=%b result=%0d err=%b want all 0", gnt, done, result, err); end
    tests++; if (core_rst !== 1'b1 || core_x !== 8'd0 || core_y !== 8'd0) begin fails++; $display("FAIL midrst_core: got core_rst=%b x=%0d y=%0d want 1/0/0", core_rst, core_x, core_y); end
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin step(); if (done !== '0) seen = 1'b1; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midrst_no_done: got %b want 0", seen); end
    set_op(2, 8'd9, 8'd6); set_op(3, 8'd6, 8'd4);
    req = 4'b1100; #1;
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL midrst_regrant: got %b want 0100", gnt); end
    wait_done(100, 4'b1111, lat, low);
    tests++; if (done !== 4'b0100 || result !== 8'd3) begin fails++; $display("FAIL midrst_result: got done=%b result=%0d want 0100/3", done, result); end
    step();
  endtask

  task automatic test_worst_case();
    int lat; bit low;
    set_op(3, 8'd255, 8'd1);
    req = 4'b1000; #1;
    tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL worst_gnt: got %b want 1000", gnt); end
    wait_done(1100, 4'b1000, lat, low);
    tests++; if (lat !== 512) begin fails++; $display("FAIL worst_latency: got %0d want 512", lat); end
    tests++; if (done !== 4'b1000 || result !== 8'd1 || err !== 1'b0) begin fails++; $display("FAIL worst_result: got done=%b result=%0d err=%b want 1000/1/0", done, result, err); end
    step();
  endtask

  initial begin
    rst = 1'b0; req = '0; a_in = '0; b_in = '0;
    w_req = '0; w_a = '0; w_b = '0; w_core_done = 1'b0; w_core_result = '0;
    test_reset();
    test_single();
    test_contention();
    test_bypass();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_run();
    test_worst_case();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded 500000 time units");
    $fatal(1);
  end

endmodule
